// File: rtl/serial_fas_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_fas_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic OpAdd = 1'b1;
  localparam logic OpSub = 1'b0;

endpackage

// File: rtl/fas.sv
// One-bit full adder/subtractor cell; cout is the carry when adding, the borrow when subtracting.
module fas
  import serial_fas_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);

  logic a_eff;

  // Inverting a turns the majority carry into a borrow.
  assign a_eff = (a_ns == OpAdd) ? a : ~a;
  assign s     = a ^ b ^ cin;
  assign cout  = (a_eff & b) | (a_eff & cin) | (b & cin);

endmodule

// File: rtl/serial_fas.sv
// Bit-serial adder/subtractor: one fas cell plus a carry/borrow flop, LSB first over WIDTH cycles.
module serial_fas
  import serial_fas_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             a_ns,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic             op_q, op_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic cell_s;
  logic cell_c;

  fas u_fas (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (c_q),
    .a_ns (op_q),
    .s    (cell_s),
    .cout (cell_c)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_d       = res_q;
    c_d         = c_q;
    op_d        = op_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    start_ready = 1'b0;
    res_valid   = 1'b0;

    case (state_q)
      StIdle: begin
        start_ready = 1'b1;
        if (start_valid) begin
          state_d = StRun;
          a_sh_d  = op_a;
          b_sh_d  = op_b;
          op_d    = a_ns;
          c_d     = 1'b0;
          cnt_d   = '0;
          a_msb_d = op_a[WIDTH-1];
          b_msb_d = op_b[WIDTH-1];
        end
      end
      StRun: begin
        res_d  = {cell_s, res_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = cell_c;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StDone;
          cout_d  = cell_c;
          // cell_s is the result MSB on the last bit.
          if (op_q == OpSub) begin
            ovf_d = (a_msb_q != b_msb_q) & (cell_s != a_msb_q);
          end else begin
            ovf_d = (a_msb_q == b_msb_q) & (cell_s != a_msb_q);
          end
        end
      end
      StDone: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      op_q    <= OpAdd;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      c_q     <= c_d;
      op_q    <= op_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign result = res_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_fas.sv
// Self-checking bench for serial_fas: directed literal cases plus an arithmetic reference model.
module tb_serial_fas;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic         a_ns = 1'b1;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  serial_fas #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_ns        (a_ns),
    .op_a        (op_a),
    .op_b        (op_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, returns {result, carry/borrow, overflow}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic add);
    int r;
    int sr;
    int sa;
    int sb;
    logic c;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (add) begin
      r  = int'(a) + int'(b);
      c  = (r > 255);
      sr = sa + sb;
    end else begin
      r  = int'(a) - int'(b);
      c  = (a < b);
      sr = sa - sb;
    end
    return {r[W-1:0], c, (sr > 127) || (sr < -128)};
  endfunction

  // Model-based monitor, sampled on the falling edge.
  logic         outstanding = 1'b0;
  int           acc_cyc = 0;
  logic [W+1:0] exp_v;

  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 1'b0;
    end else begin
      check("mon_start_ready", int'(start_ready), int'(!outstanding));
      check("mon_res_valid", int'(res_valid), int'(outstanding && (cyc - acc_cyc >= W + 1)));
      if (res_valid && outstanding) begin
        check("mon_result", int'(result), int'(exp_v[W+1:2]));
        check("mon_cout", int'(cout), int'(exp_v[1]));
        check("mon_ovf", int'(ovf), int'(exp_v[0]));
        if (res_ready) outstanding = 1'b0;
      end
      if (start_valid && !outstanding && start_ready) begin
        outstanding = 1'b1;
        acc_cyc     = cyc;
        exp_v       = model(op_a, op_b, a_ns);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ns);
    int n;
    n = 0;
    start_valid = 1'b1;
    op_a = a;
    op_b = b;
    a_ns = ns;
    while (!start_ready && n < 50) begin
      tick();
      n++;
    end
    if (!start_ready) check("send_timeout", 0, 1);
    tick();
    start_valid = 1'b0;
    op_a = W'($urandom);
    op_b = W'($urandom);
    a_ns = 1'($urandom);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    if (!res_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ns, input int er, input int ec, input int eo);
    int n;
    send(a, b, ns);
    wait_valid(n);
    check({name, "_latency"}, n, W);
    check({name, "_result"}, int'(result), er);
    check({name, "_cout"}, int'(cout), ec);
    check({name, "_ovf"}, int'(ovf), eo);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({name, "_ready_after"}, int'(start_ready), 1);
  endtask

  initial begin
    int n;
    repeat (2) tick();
    rst_n = 1'b1;
    check("rst_start_ready", int'(start_ready), 1);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_result", int'(result), 0);
    check("rst_cout", int'(cout), 0);
    check("rst_ovf", int'(ovf), 0);

    directed("add_plain", 8'h35, 8'h4A, 1'b1, 'h7F, 0, 0);
    directed("add_sovf", 8'h7F, 8'h01, 1'b1, 'h80, 0, 1);
    directed("add_carry", 8'hFF, 8'h01, 1'b1, 'h00, 1, 0);
    directed("sub_borrow", 8'h10, 8'h20, 1'b0, 'hF0, 1, 0);
    directed("sub_sovf", 8'h80, 8'h01, 1'b0, 'h7F, 0, 1);

    // Backpressure, with stray start pulses during RUN and DONE.
    send(8'hC3, 8'h5A, 1'b1);
    tick();
    start_valid = 1'b1;
    op_a = 8'h11;
    tick();
    start_valid = 1'b0;
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      check("bp_result", int'(result), 'h1D);
      check("bp_cout", int'(cout), 1);
      check("bp_ovf", int'(ovf), 0);
      check("bp_start_ready", int'(start_ready), 0);
      check("bp_res_valid", int'(res_valid), 1);
      start_valid = (i == 2);
      tick();
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_idle_ready", int'(start_ready), 1);
    check("bp_idle_valid", int'(res_valid), 0);

    // Reset during RUN cycle 4.
    send(8'hFF, 8'hFF, 1'b1);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_start_ready", int'(start_ready), 1);
    check("mid_rst_res_valid", int'(res_valid), 0);
    check("mid_rst_result", int'(result), 0);
    check("mid_rst_cout", int'(cout), 0);
    directed("post_rst", 8'h01, 8'h01, 1'b1, 'h02, 0, 0);

    // Random back-to-back traffic with random consumer stalls.
    for (int k = 0; k < 1000; k++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
      n = 0;
      while (n < 100) begin
        res_ready = ($urandom_range(0, 2) == 0);
        if (res_valid && res_ready) begin
          tick();
          break;
        end
        tick();
        n++;
      end
      res_ready = 1'b0;
      if (n >= 100) check("rand_timeout", 0, 1);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
